// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one registered memory port among NUM_PORTS multicycle masters,
// with round-robin or fixed-priority selection and an optional response watchdog.
module mem_arbiter #(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned FIXED_PRIORITY = 0,
    parameter int unsigned TIMEOUT        = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_PORTS-1:0]                port_read,
    input  logic [NUM_PORTS-1:0]                port_write,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   port_byte_enable,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     port_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]     port_wdata,
    output logic [NUM_PORTS-1:0]                port_resp,
    output logic [NUM_PORTS-1:0]                port_err,
    output logic [DATA_WIDTH-1:0]               port_rdata,
    output logic                                mem_read,
    output logic                                mem_write,
    output logic [DATA_WIDTH/8-1:0]             mem_byte_enable,
    output logic [ADDR_WIDTH-1:0]               mem_address,
    output logic [DATA_WIDTH-1:0]               mem_wdata,
    input  logic [DATA_WIDTH-1:0]               mem_rdata,
    input  logic                                mem_resp
);
    localparam int unsigned BW = DATA_WIDTH / 8;
    localparam int unsigned IW = $clog2(NUM_PORTS);
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] TLIM = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 r_state, w_next;
    logic [IW-1:0]          r_last_grant, r_grant, w_win, w_cand;
    logic [CW-1:0]          r_cnt;
    logic                   r_read, r_write;
    logic [BW-1:0]          r_be, w_sel_be;
    logic [ADDR_WIDTH-1:0]  r_addr, w_sel_addr;
    logic [DATA_WIDTH-1:0]  r_wdata, w_sel_wdata;
    logic [NUM_PORTS-1:0]   w_req;
    logic                   w_any, w_found, w_sel_wr, w_timeout;

    // Candidate order: rotating from last_grant+1, or plain index order for fixed priority.
    always_comb begin
        w_req   = port_read | port_write;
        w_any   = |w_req;
        w_win   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            w_cand = (FIXED_PRIORITY != 0) ? IW'(k)
                                           : IW'((32'(r_last_grant) + k + 1) % NUM_PORTS);
            if (!w_found && w_req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_be    = '0;
        w_sel_wr    = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (w_win == IW'(i)) begin
                w_sel_addr  = port_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = port_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_be    = port_byte_enable[i*BW +: BW];
                w_sel_wr    = port_write[i];
            end
        end
    end

    // A response in the watchdog's final cycle takes precedence over the abort.
    always_comb begin
        w_next    = r_state;
        port_resp = '0;
        port_err  = '0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: if (w_any) w_next = BUSY;
            BUSY: begin
                w_timeout = (TIMEOUT != 0) && (r_cnt == TLIM) && !mem_resp;
                if (mem_resp) begin
                    port_resp[r_grant] = 1'b1;
                    w_next             = IDLE;
                end else if (w_timeout) begin
                    port_err[r_grant] = 1'b1;
                    w_next            = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= IW'(NUM_PORTS - 1);
            r_grant      <= '0;
            r_cnt        <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_be         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else if (r_state == IDLE) begin
            if (w_any) begin
                r_grant      <= w_win;
                r_last_grant <= w_win;
                r_read       <= !w_sel_wr;
                r_write      <= w_sel_wr;
                r_be         <= w_sel_be;
                r_addr       <= w_sel_addr;
                r_wdata      <= w_sel_wdata;
                r_cnt        <= '0;
            end
        end else if (w_next == IDLE) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign mem_read        = r_read;
    assign mem_write       = r_write;
    assign mem_byte_enable = r_be;
    assign mem_address     = r_addr;
    assign mem_wdata       = r_wdata;
    assign port_rdata      = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level model; a second fixed-priority instance gets directed checks.
module tb_mem_arbiter;
    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0]    port_read = '0, port_write = '0, port_resp, port_err;
    logic [NP*BW-1:0] port_byte_enable = '0;
    logic [NP*AW-1:0] port_address = '0;
    logic [NP*DW-1:0] port_wdata = '0;
    logic [DW-1:0]    port_rdata, mem_wdata, mem_rdata = '0;
    logic             mem_read, mem_write, mem_resp = 1'b0;
    logic [BW-1:0]    mem_byte_enable;
    logic [AW-1:0]    mem_address;

    mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                  .FIXED_PRIORITY(0), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .port_read(port_read), .port_write(port_write),
        .port_byte_enable(port_byte_enable), .port_address(port_address),
        .port_wdata(port_wdata), .port_resp(port_resp), .port_err(port_err),
        .port_rdata(port_rdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp));

    logic [NP-1:0]    f_read = '0, f_write = '0, f_resp, f_err;
    logic [NP*BW-1:0] f_be = '0;
    logic [NP*AW-1:0] f_addr = '0;
    logic [NP*DW-1:0] f_wdata = '0;
    logic [DW-1:0]    f_rdata, f_mwdata, f_mrdata = '0;
    logic             f_mrd, f_mwr, f_mresp = 1'b0;
    logic [BW-1:0]    f_mbe;
    logic [AW-1:0]    f_maddr;

    mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                  .FIXED_PRIORITY(1), .TIMEOUT(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .port_read(f_read), .port_write(f_write),
        .port_byte_enable(f_be), .port_address(f_addr),
        .port_wdata(f_wdata), .port_resp(f_resp), .port_err(f_err),
        .port_rdata(f_rdata), .mem_read(f_mrd), .mem_write(f_mwr),
        .mem_byte_enable(f_mbe), .mem_address(f_maddr),
        .mem_wdata(f_mwdata), .mem_rdata(f_mrdata), .mem_resp(f_mresp));

    // Transaction-level model of the main instance.
    bit          m_busy, m_wr;
    int          m_grant, m_last, m_cycles, m_lat;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [BW-1:0] m_be;
    logic [NP-1:0] e_resp, e_err, ms_rd, ms_wr;
    int          force_lat;
    bit          force_rdata_en;
    logic [DW-1:0] force_rdata;
    int          checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_mem_read"}, mem_read, 0);
        chk({t, "_mem_write"}, mem_write, 0);
        chk({t, "_mem_address"}, mem_address, 0);
        chk({t, "_mem_wdata"}, mem_wdata, 0);
        chk({t, "_mem_be"}, mem_byte_enable, 0);
        chk({t, "_port_resp"}, port_resp, 0);
        chk({t, "_port_err"}, port_err, 0);
    endtask

    task automatic model_reset();
        m_busy = 0; m_last = NP - 1; m_cycles = 0; m_grant = 0; m_wr = 0;
    endtask

    // spur: 0 never, 1 random, 2 always pulse mem_resp while the model is idle
    task automatic drive_mem(input int spur);
        mem_rdata = force_rdata_en ? force_rdata : DW'($urandom);
        if (m_busy) mem_resp = (m_cycles + 1 == m_lat);
        else        mem_resp = (spur == 2) || (spur == 1 && $urandom_range(0, 7) == 0);
    endtask

    task automatic eval();
        int p;
        #1;
        e_resp = '0;
        e_err  = '0;
        if (m_busy) begin
            if (mem_resp)              e_resp[m_grant] = 1'b1;
            else if (m_cycles + 1 == TO) e_err[m_grant] = 1'b1;
        end
        chk("port_resp", port_resp, e_resp);
        chk("port_err", port_err, e_err);
        chk("mem_read", mem_read, m_busy && !m_wr);
        chk("mem_write", mem_write, m_busy && m_wr);
        if (m_busy) begin
            chk("mem_address", mem_address, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_byte_enable", mem_byte_enable, m_be);
        end
        if (|e_resp) chk("port_rdata", port_rdata, mem_rdata);
        if (m_busy) begin
            if (mem_resp || (|e_err)) m_busy = 0;
            else                      m_cycles++;
        end else begin
            for (int k = 1; k <= NP; k++) begin
                p = (m_last + k) % NP;
                if (port_read[p] || port_write[p]) begin
                    m_busy = 1; m_cycles = 0; m_grant = p; m_last = p;
                    m_wr    = port_write[p];
                    m_addr  = port_address[p*AW +: AW];
                    m_wdata = port_wdata[p*DW +: DW];
                    m_be    = port_byte_enable[p*BW +: BW];
                    m_lat   = (force_lat != 0) ? force_lat : $urandom_range(1, TO + 1);
                    break;
                end
            end
        end
    endtask

    // One modelled cycle; caller has already advanced to the negedge and set port data.
    task automatic step(input int spur);
        port_read  = ms_rd;
        port_write = ms_wr;
        drive_mem(spur);
        eval();
        for (int p = 0; p < NP; p++)
            if (e_resp[p] || e_err[p]) begin ms_rd[p] = 0; ms_wr[p] = 0; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; ms_rd = '0; ms_wr = '0; port_read = '0; port_write = '0;
        mem_resp = 0; f_read = '0; f_write = '0; f_mresp = 0;
        #1;
        chk_zero("reset");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        step(0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "time limit");
    end

    initial begin
        int order[$];
        int n_rd;
        bit got;
        force_lat = 0; force_rdata_en = 0; force_rdata = '0;
        ms_rd = '0; ms_wr = '0;
        model_reset();

        // Single read: latency 3, fixed read data.
        do_reset();
        force_lat = 3; force_rdata_en = 1; force_rdata = 32'hDEAD_BEEF;
        @(negedge clk); ms_rd = 3'b001; port_address[0 +: AW] = 32'h0000_1000; step(0);
        n_rd = 0; got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk); step(0);
            if (mem_read) n_rd++;
            if (port_resp != 0) begin
                got = 1;
                chk("single_resp", port_resp, 3'b001);
                chk("single_rdata", port_rdata, 32'hDEAD_BEEF);
            end
        end
        chk("single_got_resp", got, 1);
        chk("single_read_cycles", n_rd, 3);
        force_rdata_en = 0;

        // Round-robin from reset: ports 0 and 1 request continuously.
        do_reset();
        force_lat = 1;
        port_address[0 +: AW] = 32'hA000_0000;
        port_address[AW +: AW] = 32'hB000_0000;
        for (int c = 0; c < 20 && order.size() < 4; c++) begin
            @(negedge clk); ms_rd = 3'b011; step(0);
            if (port_resp == 3'b001) begin order.push_back(0); chk("rr_addr0", mem_address, 32'hA000_0000); end
            if (port_resp == 3'b010) begin order.push_back(1); chk("rr_addr1", mem_address, 32'hB000_0000); end
        end
        chk("rr_count", order.size(), 4);
        for (int i = 0; i < order.size(); i++) chk("rr_order", order[i], i % 2);

        // Write wins over read on the same port.
        do_reset();
        force_lat = 2;
        @(negedge clk);
        ms_rd = 3'b010; ms_wr = 3'b010;
        port_address[AW +: AW] = 32'h0000_2000;
        port_wdata[DW +: DW] = 32'h1234_5678;
        port_byte_enable[BW +: BW] = 4'b0110;
        step(0);
        @(negedge clk); step(0);
        chk("wr_mem_write", mem_write, 1);
        chk("wr_mem_read", mem_read, 0);
        chk("wr_be", mem_byte_enable, 4'b0110);
        chk("wr_wdata", mem_wdata, 32'h1234_5678);
        @(negedge clk); step(0);
        chk("wr_resp", port_resp, 3'b010);

        // Timeout with no response, then a late response in IDLE.
        do_reset();
        force_lat = 99;
        @(negedge clk); ms_rd = 3'b100; port_address[2*AW +: AW] = 32'h0000_3000; step(0);
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk); step(0);
            chk("to_read_held", mem_read, 1);
            chk("to_err", port_err, (c == TO) ? 3'b100 : 3'b000);
            chk("to_no_resp", port_resp, 0);
        end
        @(negedge clk); step(2);
        chk("to_read_dropped", mem_read, 0);
        chk("to_late_resp", port_resp, 0);

        // Reset two cycles into a read that followed a port-0 grant.
        do_reset();
        force_lat = 99;
        port_address[0 +: AW] = 32'h0000_4000;
        port_address[AW +: AW] = 32'h0000_5000;
        @(negedge clk); ms_rd = 3'b011; step(0);
        @(negedge clk); step(0);
        @(negedge clk); step(0);
        @(negedge clk); rst_n = 0; #1; chk_zero("midreset"); model_reset();
        @(negedge clk); rst_n = 1; ms_rd = 3'b011; step(0);
        @(negedge clk); step(0);
        chk("midreset_first_read", mem_read, 1);
        chk("midreset_first_addr", mem_address, 32'h0000_4000);

        // Fixed priority instance: ports 0 and 2 both request.
        do_reset();
        force_lat = 0;
        f_addr[0 +: AW] = 32'h0000_0100;
        f_addr[2*AW +: AW] = 32'h0000_0300;
        f_read = 3'b101;
        for (int t = 0; t < 4; t++) begin
            if (t == 3) begin @(negedge clk); f_read = 3'b100; f_mresp = 0; end
            else        begin @(negedge clk); f_mresp = 0; end
            @(negedge clk); f_mresp = 1; #1;
            chk("fp_resp", f_resp, (t == 3) ? 3'b100 : 3'b001);
            chk("fp_addr", f_maddr, (t == 3) ? 32'h0000_0300 : 32'h0000_0100);
        end
        @(negedge clk); f_mresp = 0; f_read = '0;

        // Randomized traffic against the model.
        do_reset();
        force_lat = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (!ms_rd[p] && !ms_wr[p] && $urandom_range(0, 2) == 0) begin
                    int op;
                    op = $urandom_range(0, 2);
                    ms_rd[p] = (op != 1);
                    ms_wr[p] = (op != 0);
                end
                port_address[p*AW +: AW]     = AW'($urandom);
                port_wdata[p*DW +: DW]       = DW'($urandom);
                port_byte_enable[p*BW +: BW] = BW'($urandom);
            end
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
